// File: rtl/free_list_banked_pkg.sv
// Shared free-list constants and helpers for the banked PR free list.
// Optional FREE_LIST_DOUBLE_FREE_CHECK_EN adds the double-free tracker.
package free_list_banked_pkg;

    localparam int PR_COUNT                  = 128;
    localparam int LOG_PR_COUNT              = $clog2(PR_COUNT);
    localparam int AR_COUNT                  = 32;
    localparam int FREE_LIST_BANK_COUNT      = 4;
    localparam int FREE_LIST_LENGTH_PER_BANK = PR_COUNT / FREE_LIST_BANK_COUNT;
    localparam int FREE_LIST_LOWER_THRESHOLD = 8;
    localparam int FREE_LIST_UPPER_THRESHOLD = 24;
    localparam int FREE_LIST_ENQ_PORTS       = 4;

    // Pointer sums never exceed 2*len, so one conditional subtract wraps them.
    function automatic int fl_wrap(input int v, input int len);
        return (v >= len) ? v - len : v;
    endfunction

    function automatic int fl_init_tag(input int k, input int bank,
                                       input int ar, input int banks);
        return ar + k * banks + bank;
    endfunction

endpackage

// File: rtl/free_list_bank_fifo.sv
// One circular free-list bank: up to N_WR in-order writes and one pop per
// cycle, reset-loaded with the bank's initially free PR tags.
module free_list_bank_fifo
    import free_list_banked_pkg::*;
#(
    parameter int PR_COUNT   = 128,
    parameter int AR_COUNT   = 32,
    parameter int BANK_COUNT = 4,
    parameter int BANK       = 0,
    parameter int N_WR       = 4,
    localparam int TW   = $clog2(PR_COUNT),
    localparam int LEN  = PR_COUNT / BANK_COUNT,
    localparam int CW   = $clog2(LEN) + 1
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic [N_WR-1:0]  wr_en,
    input  logic [N_WR*TW-1:0] wr_data,
    input  logic             rd_en,
    output logic [TW-1:0]    head_PR,
    output logic [CW-1:0]    count
);

    localparam int LOG_LEN = $clog2(LEN);
    localparam int PW      = (LOG_LEN > 0) ? LOG_LEN : 1;
    localparam int INIT    = (PR_COUNT - AR_COUNT) / BANK_COUNT;

    logic [TW-1:0] mem [LEN];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] tail_next;
    logic [PW-1:0] wr_idx [N_WR];
    logic [CW-1:0] count_next;

    assign head_PR = mem[head];

    // wr_en is packed from bit 0 upward, so its popcount is the write count.
    always_comb begin
        int n_wr;
        n_wr = 0;
        for (int i = 0; i < N_WR; i++) begin
            wr_idx[i] = PW'(fl_wrap(int'(tail) + i, LEN));
            n_wr += int'(wr_en[i]);
        end
        tail_next  = PW'(fl_wrap(int'(tail) + n_wr, LEN));
        count_next = CW'(int'(count) + n_wr - int'(rd_en));
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            for (int k = 0; k < LEN; k++) begin
                mem[k] <= (k < INIT)
                    ? TW'(fl_init_tag(k, BANK, AR_COUNT, BANK_COUNT))
                    : '0;
            end
            head  <= '0;
            tail  <= PW'(INIT % LEN);
            count <= CW'(INIT);
        end else begin
            for (int i = 0; i < N_WR; i++) begin
                if (wr_en[i]) begin
                    mem[wr_idx[i]] <= wr_data[i*TW +: TW];
                end
            end
            if (rd_en) begin
                head <= PW'(fl_wrap(int'(head) + 1, LEN));
            end
            tail  <= tail_next;
            count <= count_next;
        end
    end

endmodule

// File: rtl/free_list_banked.sv
// Banked physical-register free list with per-bank watermarks.
// Define FREE_LIST_DOUBLE_FREE_CHECK_EN to add double_free_err tracking.
module free_list_banked
    import free_list_banked_pkg::*;
#(
    parameter int PR_COUNT        = free_list_banked_pkg::PR_COUNT,
    parameter int AR_COUNT        = free_list_banked_pkg::AR_COUNT,
    parameter int BANK_COUNT      = FREE_LIST_BANK_COUNT,
    parameter int ENQ_PORTS       = FREE_LIST_ENQ_PORTS,
    parameter int LOWER_THRESHOLD = FREE_LIST_LOWER_THRESHOLD,
    parameter int UPPER_THRESHOLD = FREE_LIST_UPPER_THRESHOLD,
    localparam int TW  = $clog2(PR_COUNT),
    localparam int CW  = $clog2(PR_COUNT / BANK_COUNT) + 1
) (
    input  logic                    CLK,
    input  logic                    rst,
    input  logic [ENQ_PORTS-1:0]    enq_valid,
    input  logic [ENQ_PORTS*TW-1:0] enq_PR,
    output logic [BANK_COUNT-1:0]   deq_valid,
    output logic [BANK_COUNT*TW-1:0] deq_PR,
    input  logic [BANK_COUNT-1:0]   deq_ready,
    output logic [BANK_COUNT*CW-1:0] bank_count,
    output logic [BANK_COUNT-1:0]   bank_low,
    output logic [BANK_COUNT-1:0]   bank_high,
    output logic                    overflow_err
`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
    ,
    output logic                    double_free_err
`endif
);

    localparam int LEN      = PR_COUNT / BANK_COUNT;
    localparam int LOG_BANK = $clog2(BANK_COUNT);

    logic [CW-1:0]          cnt     [BANK_COUNT];
    logic [TW-1:0]          head    [BANK_COUNT];
    logic [ENQ_PORTS-1:0]   wr_en   [BANK_COUNT];
    logic [ENQ_PORTS*TW-1:0] wr_data [BANK_COUNT];
    logic [BANK_COUNT-1:0]  pop;
    logic [ENQ_PORTS-1:0]   accept;
    logic                   ovf_hit;

    for (genvar b = 0; b < BANK_COUNT; b++) begin : g_bank
        free_list_bank_fifo #(
            .PR_COUNT   (PR_COUNT),
            .AR_COUNT   (AR_COUNT),
            .BANK_COUNT (BANK_COUNT),
            .BANK       (b),
            .N_WR       (ENQ_PORTS)
        ) u_fifo (
            .CLK     (CLK),
            .rst     (rst),
            .wr_en   (wr_en[b]),
            .wr_data (wr_data[b]),
            .rd_en   (pop[b]),
            .head_PR (head[b]),
            .count   (cnt[b])
        );

        assign deq_valid[b]          = (cnt[b] != '0);
        assign pop[b]                = deq_ready[b] & deq_valid[b];
        assign deq_PR[b*TW +: TW]    = head[b];
        assign bank_count[b*CW +: CW] = cnt[b];
        assign bank_low[b]           = int'(cnt[b]) < LOWER_THRESHOLD;
        assign bank_high[b]          = int'(cnt[b]) > UPPER_THRESHOLD;
    end

    // A pop frees its slot in the same cycle, so a full bank can still
    // take one write when it is also being popped.
    always_comb begin
        int n;
        int space;
        ovf_hit = 1'b0;
        accept  = '0;
        for (int b = 0; b < BANK_COUNT; b++) begin
            wr_en[b]   = '0;
            wr_data[b] = '0;
            n     = 0;
            space = LEN - int'(cnt[b]) + int'(pop[b]);
            for (int p = 0; p < ENQ_PORTS; p++) begin
                if (enq_valid[p] &&
                    enq_PR[p*TW +: LOG_BANK] == LOG_BANK'(b)) begin
                    if (n < space) begin
                        wr_en[b][n]              = 1'b1;
                        wr_data[b][n*TW +: TW]   = enq_PR[p*TW +: TW];
                        accept[p]                = 1'b1;
                    end else begin
                        ovf_hit = 1'b1;
                    end
                    n++;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            overflow_err <= 1'b0;
        end else if (ovf_hit) begin
            overflow_err <= 1'b1;
        end
    end

`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
    logic [PR_COUNT-1:0] free_vec;
    logic [PR_COUNT-1:0] free_next;
    logic                dfe_hit;

    always_comb begin
        free_next = free_vec;
        dfe_hit   = 1'b0;
        for (int p = 0; p < ENQ_PORTS; p++) begin
            if (enq_valid[p]) begin
                if (free_vec[enq_PR[p*TW +: TW]]) begin
                    dfe_hit = 1'b1;
                end
                for (int q = p + 1; q < ENQ_PORTS; q++) begin
                    if (enq_valid[q] &&
                        enq_PR[q*TW +: TW] == enq_PR[p*TW +: TW]) begin
                        dfe_hit = 1'b1;
                    end
                end
            end
        end
        for (int b = 0; b < BANK_COUNT; b++) begin
            if (pop[b]) begin
                free_next[head[b]] = 1'b0;
            end
        end
        for (int p = 0; p < ENQ_PORTS; p++) begin
            if (accept[p]) begin
                free_next[enq_PR[p*TW +: TW]] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            for (int i = 0; i < PR_COUNT; i++) begin
                free_vec[i] <= (i >= AR_COUNT);
            end
            double_free_err <= 1'b0;
        end else begin
            free_vec <= free_next;
            if (dfe_hit) begin
                double_free_err <= 1'b1;
            end
        end
    end
`endif

endmodule
